// File: rtl/s3_execute_writeback_if.sv
// Stage-2 to stage-3 bus for s3_execute_writeback: S2 operand/control fields in,
// registered register-file write port and the combinational stall back out.
interface s3_execute_writeback_if;
    logic [31:0] S2_ReadData1;
    logic [31:0] S2_ReadData2;
    logic [15:0] S2_Imm;
    logic        S2_DataSrc;
    logic [2:0]  S2_ALUOp;
    logic [4:0]  S2_WriteSelect;
    logic        S2_WriteEnable;
    logic [31:0] S3_ALUOut;
    logic [4:0]  S3_WriteSelect;
    logic        S3_WriteEnable;
    logic        S3_Stall;

    modport master (
        output S2_ReadData1, S2_ReadData2, S2_Imm, S2_DataSrc, S2_ALUOp,
               S2_WriteSelect, S2_WriteEnable,
        input  S3_ALUOut, S3_WriteSelect, S3_WriteEnable, S3_Stall
    );

    modport slave (
        input  S2_ReadData1, S2_ReadData2, S2_Imm, S2_DataSrc, S2_ALUOp,
               S2_WriteSelect, S2_WriteEnable,
        output S3_ALUOut, S3_WriteSelect, S3_WriteEnable, S3_Stall
    );
endinterface

// File: rtl/s3_execute_writeback.sv
// Execute/writeback stage: single-cycle ALU with registered write port.
// Define S3_MUL_EN to add the 4-step byte-serial multiplier (op 111) with stall.
module s3_execute_writeback (
    input  logic                  clk,
    input  logic                  rst,
    s3_execute_writeback_if.slave bus
);
    logic [31:0] op_b_s;
    logic [31:0] alu_res_s;
    logic [31:0] alu_out_r, alu_out_s;
    logic [4:0]  ws_r, ws_s;
    logic        we_r, we_s;
    logic        stall_s;

    // Operand B mux and single-cycle ALU; op 111 yields 0 here, the multiplier owns it
    always_comb begin
        op_b_s    = bus.S2_DataSrc ? {{16{bus.S2_Imm[15]}}, bus.S2_Imm} : bus.S2_ReadData2;
        alu_res_s = 32'd0;
        case (bus.S2_ALUOp)
            3'b000:  alu_res_s = bus.S2_ReadData1 + op_b_s;
            3'b001:  alu_res_s = bus.S2_ReadData1 - op_b_s;
            3'b010:  alu_res_s = bus.S2_ReadData1 & op_b_s;
            3'b011:  alu_res_s = bus.S2_ReadData1 | op_b_s;
            3'b100:  alu_res_s = bus.S2_ReadData1 ^ op_b_s;
            3'b101:  alu_res_s = bus.S2_ReadData1 << op_b_s[4:0];
            3'b110:  alu_res_s = ($signed(bus.S2_ReadData1) < $signed(op_b_s)) ? 32'd1 : 32'd0;
            default: alu_res_s = 32'd0;
        endcase
    end

`ifdef S3_MUL_EN
    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_r, state_s;
    logic [1:0]  cnt_r, cnt_s;
    logic [31:0] acc_r, acc_s;
    logic [31:0] a_r, a_s;
    logic [31:0] b_r, b_s;
    logic [4:0]  ws_cap_r, ws_cap_s;
    logic        we_cap_r, we_cap_s;
    logic [7:0]  b_byte_s;
    logic [31:0] prod_s;
    logic [31:0] partial_s;

    // One byte of B per step; truncation to 32 bits matches low-word product semantics
    always_comb begin
        b_byte_s  = b_r[{cnt_r, 3'b000} +: 8];
        prod_s    = a_r * {24'd0, b_byte_s};
        partial_s = prod_s << {cnt_r, 3'b000};
    end

    // Next-state, capture and write-port logic
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        acc_s     = acc_r;
        a_s       = a_r;
        b_s       = b_r;
        ws_cap_s  = ws_cap_r;
        we_cap_s  = we_cap_r;
        alu_out_s = alu_out_r;
        ws_s      = ws_r;
        we_s      = we_r;
        stall_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.S2_ALUOp == 3'b111) begin
                    stall_s  = 1'b1;
                    a_s      = bus.S2_ReadData1;
                    b_s      = op_b_s;
                    ws_cap_s = bus.S2_WriteSelect;
                    we_cap_s = bus.S2_WriteEnable;
                    acc_s    = 32'd0;
                    cnt_s    = 2'd0;
                    we_s     = 1'b0;
                    state_s  = BUSY;
                end else begin
                    alu_out_s = alu_res_s;
                    ws_s      = bus.S2_WriteSelect;
                    we_s      = bus.S2_WriteEnable;
                end
            end
            BUSY: begin
                acc_s = acc_r + partial_s;
                cnt_s = cnt_r + 2'd1;
                we_s  = 1'b0;
                if (cnt_r == 2'd3) begin
                    alu_out_s = acc_r + partial_s;
                    ws_s      = ws_cap_r;
                    we_s      = we_cap_r;
                    state_s   = IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, multiplier and write-port registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= 2'd0;
            acc_r     <= 32'd0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            ws_cap_r  <= 5'd0;
            we_cap_r  <= 1'b0;
            alu_out_r <= 32'd0;
            ws_r      <= 5'd0;
            we_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            acc_r     <= acc_s;
            a_r       <= a_s;
            b_r       <= b_s;
            ws_cap_r  <= ws_cap_s;
            we_cap_r  <= we_cap_s;
            alu_out_r <= alu_out_s;
            ws_r      <= ws_s;
            we_r      <= we_s;
        end
    end
`else
    // Every op completes in one cycle; nothing ever stalls
    always_comb begin
        alu_out_s = alu_res_s;
        ws_s      = bus.S2_WriteSelect;
        we_s      = bus.S2_WriteEnable;
        stall_s   = 1'b0;
    end

    // Write-port registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_out_r <= 32'd0;
            ws_r      <= 5'd0;
            we_r      <= 1'b0;
        end else begin
            alu_out_r <= alu_out_s;
            ws_r      <= ws_s;
            we_r      <= we_s;
        end
    end
`endif

    assign bus.S3_ALUOut      = alu_out_r;
    assign bus.S3_WriteSelect = ws_r;
    assign bus.S3_WriteEnable = we_r;
    assign bus.S3_Stall       = stall_s;
endmodule

// File: tb/tb_s3_execute_writeback.sv
// Randomized + directed bench for s3_execute_writeback against a behavioural model;
// follows S3_MUL_EN to decide whether op 111 multiplies (5 edges) or returns 0.
module tb_s3_execute_writeback;
`ifdef S3_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    s3_execute_writeback_if bus ();

    s3_execute_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural reference: whole-word arithmetic straight from the op table
    function automatic logic [31:0] ref_exec(input logic [31:0] a, input logic [31:0] rd2,
                                             input logic [15:0] imm, input logic src,
                                             input logic [2:0] op);
        logic [31:0] b;
        int          imm_int;
        imm_int = int'($signed(imm));
        b = src ? imm_int : rd2;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return MUL_EN ? a * b : 32'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] rd2, input logic [15:0] imm,
                         input logic src, input logic [2:0] op, input logic [4:0] ws,
                         input logic we);
        bus.S2_ReadData1   = a;
        bus.S2_ReadData2   = rd2;
        bus.S2_Imm         = imm;
        bus.S2_DataSrc     = src;
        bus.S2_ALUOp       = op;
        bus.S2_WriteSelect = ws;
        bus.S2_WriteEnable = we;
    endtask

    // Present one instruction, hold it while stalled, then check the write port
    task automatic run_op(input logic [31:0] a, input logic [31:0] rd2, input logic [15:0] imm,
                          input logic src, input logic [2:0] op, input logic [4:0] ws,
                          input logic we, input logic [31:0] exp, input string name);
        int stalls;
        int exp_stalls;
        stalls     = 0;
        exp_stalls = (MUL_EN && op == 3'd7) ? 4 : 0;
        drive(a, rd2, imm, src, op, ws, we);
        #1;
        while (bus.S3_Stall === 1'b1 && stalls < 8) begin
            stalls++;
            step();
            checks++;
            if (bus.S3_WriteEnable !== 1'b0) begin
                errors++;
                $display("FAIL %s bubble_we stall%0d got %b want 0", name, stalls, bus.S3_WriteEnable);
            end
        end
        checks++;
        if (stalls !== exp_stalls) begin
            errors++;
            $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, exp_stalls);
        end
        step();
        checks++;
        if (bus.S3_ALUOut !== exp || bus.S3_WriteSelect !== ws || bus.S3_WriteEnable !== we) begin
            errors++;
            $display("FAIL %s result got %h/%0d/%b want %h/%0d/%b", name, bus.S3_ALUOut,
                     bus.S3_WriteSelect, bus.S3_WriteEnable, exp, ws, we);
        end
    endtask

    task automatic test_reset();
        drive(32'd99, 32'd1, 16'd0, 1'b0, 3'd0, 5'd4, 1'b1);
        rst = 1'b0;
        step();
        step();
        checks++;
        if (bus.S3_ALUOut !== 32'd0 || bus.S3_WriteSelect !== 5'd0 ||
            bus.S3_WriteEnable !== 1'b0 || bus.S3_Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got %h/%0d/%b/%b want 0/0/0/0", bus.S3_ALUOut,
                     bus.S3_WriteSelect, bus.S3_WriteEnable, bus.S3_Stall);
        end
        rst = 1'b1;
    endtask

    task automatic test_add();
        run_op(32'd5, 32'd7, 16'd0, 1'b0, 3'd0, 5'd3, 1'b1, 32'd12, "add");
        run_op(32'd9, 32'd5, 16'd0, 1'b0, 3'd0, 5'd0, 1'b1, 32'd14, "add_ws0");
    endtask

    task automatic test_imm();
        run_op(32'd10, 32'd0, 16'hFFFF, 1'b1, 3'd0, 5'd1, 1'b1, 32'd9, "imm_add");
        run_op(32'd10, 32'd0, 16'hFFFF, 1'b1, 3'd6, 5'd2, 1'b1, 32'd0, "imm_slt");
        run_op(32'hFFFFFFFF, 32'd1, 16'd0, 1'b0, 3'd6, 5'd2, 1'b0, 32'd1, "slt_neg");
    endtask

    task automatic test_mul();
        run_op(32'd1234, 32'd5678, 16'd0, 1'b0, 3'd7, 5'd7, 1'b1,
               MUL_EN ? 32'd7006652 : 32'd0, "mul");
        run_op(32'h00010000, 32'h00010000, 16'd0, 1'b0, 3'd7, 5'd8, 1'b1, 32'd0, "mul_ovf");
        run_op(32'hFFFFFFFF, 32'd2, 16'd0, 1'b0, 3'd7, 5'd9, 1'b1,
               MUL_EN ? 32'hFFFFFFFE : 32'd0, "mul_neg");
    endtask

    // Reset lands on the cnt=1 edge of a multiply; nothing may be written afterwards
    task automatic test_reset_abort();
        drive(32'd3, 32'd4, 16'd0, 1'b0, 3'd7, 5'd9, 1'b1);
        #1;
        checks++;
        if (bus.S3_Stall !== MUL_EN) begin
            errors++;
            $display("FAIL abort_stall got %b want %b", bus.S3_Stall, MUL_EN);
        end
        step();
        step();
        rst = 1'b0;
        drive(32'd1, 32'd1, 16'd0, 1'b0, 3'd0, 5'd5, 1'b1);
        step();
        checks++;
        if (bus.S3_ALUOut !== 32'd0 || bus.S3_WriteSelect !== 5'd0 ||
            bus.S3_WriteEnable !== 1'b0 || bus.S3_Stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got %h/%0d/%b/%b want 0/0/0/0", bus.S3_ALUOut,
                     bus.S3_WriteSelect, bus.S3_WriteEnable, bus.S3_Stall);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.S3_ALUOut !== 32'd2 || bus.S3_WriteSelect !== 5'd5 || bus.S3_WriteEnable !== 1'b1) begin
                errors++;
                $display("FAIL abort_add cyc%0d got %h/%0d/%b want 2/5/1", i, bus.S3_ALUOut,
                         bus.S3_WriteSelect, bus.S3_WriteEnable);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_op(32'd6, 32'd7, 16'd0, 1'b0, 3'd7, 5'd10, 1'b1, MUL_EN ? 32'd42 : 32'd0, "b2b_mul");
        run_op(32'd1, 32'd31, 16'd0, 1'b0, 3'd5, 5'd11, 1'b1, 32'h80000000, "b2b_sll");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] rd2;
        logic [15:0] imm;
        logic        src;
        logic [2:0]  op;
        logic [4:0]  ws;
        logic        we;
        for (int i = 0; i < 60; i++) begin
            a   = $urandom;
            rd2 = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            imm = 16'($urandom);
            src = 1'($urandom);
            op  = 3'($urandom);
            ws  = 5'($urandom);
            we  = 1'($urandom);
            run_op(a, rd2, imm, src, op, ws, we, ref_exec(a, rd2, imm, src, op), "random");
        end
    endtask

    initial begin
        drive(32'd0, 32'd0, 16'd0, 1'b0, 3'd0, 5'd0, 1'b0);
        test_reset();
        test_add();
        test_imm();
        test_mul();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
